ex_stage_module: RTL and testbench
==================================

# ex_stage_module

Execute stage of the 5-stage ARM pipeline, directly downstream of the ID stage register and upstream of the MEM stage. It consumes the decoded fields from the ID/EX register and does the following:
- forms the second ALU operand (Val2) from the shifter/immediate field;
- runs the ALU;
- computes the branch target and produces NZCV for the status register;
- captures results in the EX/MEM pipeline register.

## Interface
Parameters:
- none (all widths fixed: address/register 32, reg address 4, status 4, exec command 4)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- freeze  in  1  hold EX/MEM register contents
- pc_in  in  32  PC+4 of the instruction
- status_reg_in  in  4  current NZCV, bit 3 = N … bit 0 = V
- reg_file_out1  in  32  Rn value
- reg_file_out2  in  32  Rm value; also the store data
- signed_immediate_in  in  24  branch offset, in words
- shift_operand_in  in  12  shifter operand field
- is_immediate_in  in  1  I bit
- status_write_enable_in  in  1  S bit
- execute_command_in  in  4  ALU opcode
- mem_read_in, mem_write_in, wb_enable_in, is_branch_in  in  1 each  control bits
- dest_reg_in  in  4  Rd
- branch_taken  out  1  combinational; equals is_branch_in
- branch_address  out  32  combinational target
- status_out  out  4  combinational new NZCV
- status_ld  out  1  combinational status register load enable
- ex_dest_reg, ex_wb_enable  out  4, 1  combinational copies of the inputs, for hazard detection
- alu_result_out  out  32  registered
- store_data_out  out  32  registered Rm
- dest_reg_out  out  4  registered
- mem_read_out, mem_write_out, wb_enable_out  out  1 each  registered

## Operation
Val2 generation:
- Memory instructions (mem_read_in | mem_write_in): Val2 = zero-extended shift_operand_in[11:0]. This takes priority over the I bit.
- is_immediate_in = 1: Val2 = {24'b0, imm8[7:0]} rotated right by 2 × rot[11:8].
- Otherwise, register shifted by an immediate amount: shift_imm = [11:7], type = [6:5], applied to reg_file_out2.
  - Types: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes Rm through unchanged.
  - Bit 4 is ignored; register-specified shifts are not supported.

ALU (A = Rn, B = Val2, Cin = status_reg_in[1]):
- 0001 MOV: B
- 1001 MVN: ~B
- 0010 ADD: A+B
- 0011 ADC: A+B+Cin
- 0100 SUB/CMP: A−B
- 0101 SBC: A−B−!Cin
- 0110 AND/TST: A&B
- 0111 ORR: A|B
- 1000 EOR: A^B
- Any other code: result 0, flags unchanged.

Flags:
- N = result[31].
- Z = (result == 0).
- Arithmetic ops: compute in 33 bits.
  - C = bit 32 of A + B (+Cin) for adds, and of A + ~B + 1 (resp. + Cin) for subtracts. For subtracts, C = 1 means no borrow.
  - V = signed overflow.
- Logic and move ops: C and V pass through from status_reg_in.

Status and branch:
- status_ld = status_write_enable_in & ~freeze.
- branch_address = pc_in + (sign_extend(signed_immediate_in) << 2), computed modulo 2^32.

EX/MEM register:
- Loads all registered outputs at each rising edge when freeze = 0; holds them when freeze = 1.
- For memory instructions, alu_result_out is the effective address Rn + Val2 (opcode 0010 is supplied by the decoder).

## Timing
- Combinational outputs are valid in the same cycle the ID/EX outputs are stable.
- Registered outputs have 1-cycle latency.
- rst low clears every registered output to 0 immediately, independent of clk. Combinational outputs follow their inputs during reset.
- rst deasserting mid-stream: the first capture happens at the next rising edge with rst high.
- freeze and reset asserted together: reset wins.
- freeze held for N cycles: the registered outputs stay identical for N edges. status_ld stays 0 throughout, so flags are not applied twice.
- Wrap-around: the ALU and branch adder discard carries beyond bit 31, except the C flag.

## Test plan
- Immediate ADD: Rn = 5, I = 1, shift_operand = 0x0FF, cmd 0010, S = 1.
  - alu_result_out = 0x104 after 1 edge.
  - status_out = 0000; status_ld = 1.
- Immediate rotate: MOV, I = 1, shift_operand = 0x4FF → alu_result_out = 0xFF000000, N = 1.
- SUB producing zero: Rn = 5, Rm = 5, LSL #0, cmd 0100 → result 0, NZCV = 0110.
- Register shifts on Rm = 0x80000003:
  - LSL #2 → 0x0000000C.
  - ASR #1 → 0xC0000001.
  - ROR #4 → 0x38000000.
- ADD overflow: ADD 0x7FFFFFFF + 1 → NZCV = 1001.
- ADC with Cin = 1: 1 + 1 → 3.
- Branch: pc_in = 0x20, imm24 = 0xFFFFFE, is_branch = 1 → branch_address = 0x18, branch_taken = 1.
- Freeze and reset:
  - Load a result, assert freeze for 3 cycles while the inputs change → outputs unchanged, status_ld = 0.
  - Then pull rst low mid-cycle → all registered outputs are 0 before the next edge.

Source files
------------

// File: rtl/ex_stage_module.sv
// rtl/ex_stage_module.sv - ARM execute stage: Val2 shifter, ALU, NZCV, branch target, EX/MEM register
module ex_stage_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [31:0] pc_in,
    input  logic [3:0]  status_reg_in,
    input  logic [31:0] reg_file_out1,
    input  logic [31:0] reg_file_out2,
    input  logic [23:0] signed_immediate_in,
    input  logic [11:0] shift_operand_in,
    input  logic        is_immediate_in,
    input  logic        status_write_enable_in,
    input  logic [3:0]  execute_command_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        wb_enable_in,
    input  logic        is_branch_in,
    input  logic [3:0]  dest_reg_in,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [3:0]  status_out,
    output logic        status_ld,
    output logic [3:0]  ex_dest_reg,
    output logic        ex_wb_enable,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  dest_reg_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        wb_enable_out
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    logic        is_mem;
    logic [31:0] imm_val;
    logic [4:0]  rot_amt;
    logic [4:0]  shift_amt;
    logic [63:0] imm_dbl;
    logic [63:0] rm_dbl;
    logic [31:0] val2;
    logic [31:0] alu_result;
    logic [32:0] sum33;
    logic        cin;
    logic        flag_c;
    logic        flag_v;

    assign is_mem    = mem_read_in | mem_write_in;
    assign imm_val   = {24'b0, shift_operand_in[7:0]};
    assign rot_amt   = {shift_operand_in[11:8], 1'b0};
    assign shift_amt = shift_operand_in[11:7];
    // Rotates are done as a right shift of the word concatenated with itself.
    assign imm_dbl   = {imm_val, imm_val} >> rot_amt;
    assign rm_dbl    = {reg_file_out2, reg_file_out2} >> shift_amt;
    assign cin       = status_reg_in[1];

    always_comb begin
        val2 = reg_file_out2;
        if (is_mem) begin
            val2 = {20'b0, shift_operand_in};
        end else if (is_immediate_in) begin
            val2 = imm_dbl[31:0];
        end else begin
            case (shift_operand_in[6:5])
                2'b00:   val2 = reg_file_out2 << shift_amt;
                2'b01:   val2 = reg_file_out2 >> shift_amt;
                2'b10:   val2 = $unsigned($signed(reg_file_out2) >>> shift_amt);
                default: val2 = rm_dbl[31:0];
            endcase
        end
    end

    always_comb begin
        alu_result = 32'b0;
        sum33      = 33'b0;
        flag_c     = status_reg_in[1];
        flag_v     = status_reg_in[0];
        status_out = status_reg_in;
        case (execute_command_in)
            OP_MOV: alu_result = val2;
            OP_MVN: alu_result = ~val2;
            OP_AND: alu_result = reg_file_out1 & val2;
            OP_ORR: alu_result = reg_file_out1 | val2;
            OP_EOR: alu_result = reg_file_out1 ^ val2;
            OP_ADD, OP_ADC: begin
                sum33      = {1'b0, reg_file_out1} + {1'b0, val2}
                             + {32'b0, (execute_command_in == OP_ADC) & cin};
                alu_result = sum33[31:0];
                flag_c     = sum33[32];
                flag_v     = (reg_file_out1[31] == val2[31]) && (alu_result[31] != reg_file_out1[31]);
            end
            OP_SUB, OP_SBC: begin
                // Subtract as A + ~B + 1 (or + Cin), so C = 1 means no borrow.
                sum33      = {1'b0, reg_file_out1} + {1'b0, ~val2}
                             + {32'b0, (execute_command_in == OP_SUB) | cin};
                alu_result = sum33[31:0];
                flag_c     = sum33[32];
                flag_v     = (reg_file_out1[31] != val2[31]) && (alu_result[31] != reg_file_out1[31]);
            end
            default: alu_result = 32'b0;
        endcase
        case (execute_command_in)
            OP_MOV, OP_MVN, OP_AND, OP_ORR, OP_EOR,
            OP_ADD, OP_ADC, OP_SUB, OP_SBC:
                status_out = {alu_result[31], (alu_result == 32'b0), flag_c, flag_v};
            default: status_out = status_reg_in;
        endcase
    end

    assign status_ld      = status_write_enable_in & ~freeze;
    assign branch_taken   = is_branch_in;
    assign branch_address = pc_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};
    assign ex_dest_reg    = dest_reg_in;
    assign ex_wb_enable   = wb_enable_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_out <= 32'b0;
            store_data_out <= 32'b0;
            dest_reg_out   <= 4'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            wb_enable_out  <= 1'b0;
        end else if (!freeze) begin
            alu_result_out <= alu_result;
            store_data_out <= reg_file_out2;
            dest_reg_out   <= dest_reg_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            wb_enable_out  <= wb_enable_in;
        end
    end

endmodule

// File: tb/tb_ex_stage_module.sv
// tb/tb_ex_stage_module.sv - randomized self-checking bench for ex_stage_module
module tb_ex_stage_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [31:0] pc_in;
    logic [3:0]  status_reg_in;
    logic [31:0] reg_file_out1;
    logic [31:0] reg_file_out2;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic        is_immediate_in;
    logic        status_write_enable_in;
    logic [3:0]  execute_command_in;
    logic        mem_read_in, mem_write_in, wb_enable_in, is_branch_in;
    logic [3:0]  dest_reg_in;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  status_out;
    logic        status_ld;
    logic [3:0]  ex_dest_reg;
    logic        ex_wb_enable;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [3:0]  dest_reg_out;
    logic        mem_read_out, mem_write_out, wb_enable_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage_module dut (
        .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
        .status_reg_in(status_reg_in), .reg_file_out1(reg_file_out1),
        .reg_file_out2(reg_file_out2), .signed_immediate_in(signed_immediate_in),
        .shift_operand_in(shift_operand_in), .is_immediate_in(is_immediate_in),
        .status_write_enable_in(status_write_enable_in),
        .execute_command_in(execute_command_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in),
        .is_branch_in(is_branch_in), .dest_reg_in(dest_reg_in),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .status_out(status_out), .status_ld(status_ld), .ex_dest_reg(ex_dest_reg),
        .ex_wb_enable(ex_wb_enable), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .dest_reg_out(dest_reg_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .wb_enable_out(wb_enable_out)
    );

    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int k = 0; k < n; k++) y = (y >> 1) | ((y & 32'd1) << 31);
        return y;
    endfunction

    function automatic logic [31:0] m_asr(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int k = 0; k < n; k++) y = (y >> 1) | (y & 32'h8000_0000);
        return y;
    endfunction

    function automatic logic [31:0] m_val2(input logic [11:0] so, input logic imm,
                                           input logic mem, input logic [31:0] rm);
        int amt;
        int typ;
        if (mem) return {20'd0, so};
        if (imm) return m_ror({24'd0, so[7:0]}, 2 * int'(so >> 8));
        amt = int'(so >> 7) & 31;
        typ = int'(so >> 5) & 3;
        case (typ)
            0:       return rm << amt;
            1:       return rm >> amt;
            2:       return m_asr(rm, amt);
            default: return m_ror(rm, amt);
        endcase
    endfunction

    task automatic m_exec(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] nzcv_in, output logic [31:0] res,
                          output logic [3:0] nzcv);
        longint unsigned ua, ub, u;
        longint sa, sb, s;
        logic c, v, cin, arith, valid;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = nzcv_in[1];
        arith = 1'b1;
        valid = 1'b1;
        c = nzcv_in[1];
        v = nzcv_in[0];
        s = 0;
        u = 0;
        res = 32'd0;
        case (cmd)
            4'd1: begin res = b;     arith = 1'b0; end
            4'd9: begin res = ~b;    arith = 1'b0; end
            4'd6: begin res = a & b; arith = 1'b0; end
            4'd7: begin res = a | b; arith = 1'b0; end
            4'd8: begin res = a ^ b; arith = 1'b0; end
            4'd2: begin u = ua + ub;       s = sa + sb;       c = (u >= 64'h1_0000_0000); end
            4'd3: begin u = ua + ub + cin; s = sa + sb + cin; c = (u >= 64'h1_0000_0000); end
            4'd4: begin u = ua - ub;       s = sa - sb;       c = (ua >= ub); end
            4'd5: begin u = ua - ub - (cin ? 0 : 1); s = sa - sb - (cin ? 0 : 1);
                        c = (ua >= ub + (cin ? 0 : 1)); end
            default: begin arith = 1'b0; valid = 1'b0; end
        endcase
        if (arith) begin
            res = u[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        nzcv = valid ? {res[31], res == 32'd0, c, v} : nzcv_in;
    endtask

    task automatic drive_op(input logic [3:0] cmd, input logic imm, input logic [11:0] so,
                            input logic [31:0] rn, input logic [31:0] rm,
                            input logic [3:0] nzcv, input logic s);
        execute_command_in = cmd;
        is_immediate_in = imm;
        shift_operand_in = so;
        reg_file_out1 = rn;
        reg_file_out2 = rm;
        status_reg_in = nzcv;
        status_write_enable_in = s;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        freeze = 1'b0;
        pc_in = 32'h100; signed_immediate_in = 24'd1;
        mem_read_in = 1'b1; mem_write_in = 1'b1; wb_enable_in = 1'b1; is_branch_in = 1'b0;
        dest_reg_in = 4'hA;
        drive_op(4'd2, 1'b1, 12'h0FF, 32'd5, 32'hDEAD_BEEF, 4'd0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({alu_result_out, store_data_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out} !== 73'd0) begin
            failures++;
            $display("FAIL reset_regs got %h %h %h %b%b%b want all zero", alu_result_out, store_data_out,
                     dest_reg_out, mem_read_out, mem_write_out, wb_enable_out);
        end
        checks++;
        if (ex_dest_reg !== 4'hA || ex_wb_enable !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb_follow got %h %b want a 1", ex_dest_reg, ex_wb_enable);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    task automatic test_directed;
        logic [11:0] so_t [9] = '{12'h0FF, 12'h4FF, 12'h000, 12'h100, 12'h0C0, 12'h260, 12'h000, 12'h000, 12'h0FF};
        logic [3:0]  cmd_t[9] = '{4'd2, 4'd1, 4'd4, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd2};
        logic        imm_t[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] rn_t [9] = '{32'd5, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0};
        logic [31:0] rm_t [9] = '{32'd0, 32'd0, 32'd5, 32'h8000_0003, 32'h8000_0003, 32'h8000_0003, 32'd1, 32'd1, 32'd0};
        logic [3:0]  st_t [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0010, 4'b0011};
        logic [31:0] res_t[9] = '{32'h104, 32'hFF00_0000, 32'd0, 32'hC, 32'hC000_0001, 32'h3800_0000, 32'h8000_0000, 32'd3, 32'hFF};
        logic [3:0]  fl_t [9] = '{4'b0000, 4'b1000, 4'b0110, 4'b0000, 4'b1000, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_read_in = (i == 8);
            drive_op(cmd_t[i], imm_t[i], so_t[i], rn_t[i], rm_t[i], st_t[i], 1'b1);
            #1;
            checks++;
            if (status_out !== fl_t[i] || status_ld !== 1'b1) begin
                failures++;
                $display("FAIL directed_flags[%0d] got %b ld=%b want %b ld=1", i, status_out, status_ld, fl_t[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (alu_result_out !== res_t[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] got %h want %h", i, alu_result_out, res_t[i]);
            end
        end
        @(negedge clk);
        mem_read_in = 1'b0;
    endtask

    task automatic test_branch;
        logic [31:0] exp;
        @(negedge clk);
        pc_in = 32'h20; signed_immediate_in = 24'hFF_FFFE; is_branch_in = 1'b1;
        #1;
        checks++;
        if (branch_address !== 32'h18 || branch_taken !== 1'b1) begin
            failures++;
            $display("FAIL branch_directed got %h taken=%b want 00000018 taken=1", branch_address, branch_taken);
        end
        for (int i = 0; i < 40; i++) begin
            pc_in = $urandom;
            signed_immediate_in = 24'($urandom);
            is_branch_in = 1'($urandom);
            #1;
            exp = 32'(longint'(pc_in) + 4 * longint'($signed(signed_immediate_in)));
            checks++;
            if (branch_address !== exp || branch_taken !== is_branch_in) begin
                failures++;
                $display("FAIL branch_random got %h taken=%b want %h taken=%b", branch_address, branch_taken, exp, is_branch_in);
            end
        end
        is_branch_in = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0]  cmd_pool [12] = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd10, 4'd15};
        logic [31:0] v2, eres, rm_s;
        logic [3:0]  eflags, dr_s;
        logic        mr_s, mw_s, wb_s;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            mem_read_in = ($urandom_range(0, 5) == 0);
            mem_write_in = !mem_read_in && ($urandom_range(0, 5) == 0);
            wb_enable_in = 1'($urandom);
            dest_reg_in = 4'($urandom);
            drive_op((mem_read_in | mem_write_in) ? 4'd2 : cmd_pool[$urandom_range(0, 11)],
                     1'($urandom), 12'($urandom),
                     ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom,
                     $urandom, 4'($urandom), 1'($urandom));
            v2 = m_val2(shift_operand_in, is_immediate_in, mem_read_in | mem_write_in, reg_file_out2);
            m_exec(execute_command_in, reg_file_out1, v2, status_reg_in, eres, eflags);
            rm_s = reg_file_out2; dr_s = dest_reg_in;
            mr_s = mem_read_in; mw_s = mem_write_in; wb_s = wb_enable_in;
            #1;
            checks++;
            if (status_out !== eflags || status_ld !== status_write_enable_in ||
                ex_dest_reg !== dr_s || ex_wb_enable !== wb_s) begin
                failures++;
                $display("FAIL random_comb[%0d] cmd=%h flags=%b ld=%b want %b ld=%b", i, execute_command_in,
                         status_out, status_ld, eflags, status_write_enable_in);
            end
            @(posedge clk); #1;
            checks++;
            if (alu_result_out !== eres || store_data_out !== rm_s || dest_reg_out !== dr_s ||
                mem_read_out !== mr_s || mem_write_out !== mw_s || wb_enable_out !== wb_s) begin
                failures++;
                $display("FAIL random_reg[%0d] cmd=%h so=%h got %h %h want %h %h", i, execute_command_in,
                         shift_operand_in, alu_result_out, store_data_out, eres, rm_s);
            end
        end
        @(negedge clk);
        mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    task automatic test_freeze_reset;
        @(negedge clk);
        wb_enable_in = 1'b1; dest_reg_in = 4'h3; mem_write_in = 1'b0;
        drive_op(4'd2, 1'b0, 12'h000, 32'd10, 32'd20, 4'd0, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            freeze = 1'b1;
            dest_reg_in = 4'(i + 7); wb_enable_in = 1'b0; mem_read_in = 1'b1;
            drive_op(4'd1, 1'b1, 12'($urandom), $urandom, $urandom, 4'($urandom), 1'b1);
            #1;
            checks++;
            if (status_ld !== 1'b0) begin
                failures++;
                $display("FAIL freeze_status_ld[%0d] got %b want 0", i, status_ld);
            end
            @(posedge clk); #1;
            checks++;
            if (alu_result_out !== 32'd30 || store_data_out !== 32'd20 || dest_reg_out !== 4'h3 ||
                wb_enable_out !== 1'b1 || mem_read_out !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold[%0d] got %h %h %h want 0000001e 00000014 3", i,
                         alu_result_out, store_data_out, dest_reg_out);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({alu_result_out, store_data_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out} !== 73'd0) begin
            failures++;
            $display("FAIL midcycle_reset got %h %h %h %b want all zero", alu_result_out, store_data_out,
                     dest_reg_out, wb_enable_out);
        end
        @(negedge clk);
        freeze = 1'b0;
        rst = 1'b1;
        mem_read_in = 1'b0;
        drive_op(4'd7, 1'b1, 12'h0F0, 32'h0000_000F, 32'd1, 4'd0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (alu_result_out !== 32'h0000_00FF || dest_reg_out !== 4'h9) begin
            failures++;
            $display("FAIL first_capture_after_reset got %h %h want 000000ff 9", alu_result_out, dest_reg_out);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_branch();
        test_random();
        test_freeze_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
